// File: rtl/text_fetch_sched.sv
// text_fetch_sched: character-cell prefetch, glyph-row serialiser and host write arbiter
// for a single-port text RAM shared between display reads and host writes.
`default_nettype none

module text_fetch_sched #(
  parameter int HBP    = 144,
  parameter int VBP    = 31,
  parameter int VFP    = 511,
  parameter int COLS   = 160,
  parameter int ROWS   = 60,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_data,
  output logic              host_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        font_code,
  input  logic [31:0]       font_gfx,
  output logic              pix_on
);

  localparam logic [9:0]        HC_FETCH_PRE  = 10'(HBP - 5);
  localparam logic [9:0]        HC_FETCH_LO   = 10'(HBP - 4);
  localparam logic [9:0]        HC_FETCH_HI   = 10'(HBP + 4*COLS - 5);
  localparam logic [9:0]        HC_DISP_LO    = 10'(HBP);
  localparam logic [9:0]        HC_DISP_HI    = 10'(HBP + 4*COLS - 1);
  localparam logic [9:0]        VC_LO         = 10'(VBP);
  localparam logic [9:0]        VC_END        = 10'(VFP);
  localparam logic [ADDR_W-1:0] CELLS         = ADDR_W'(COLS*ROWS);
  localparam logic [ADDR_W-1:0] ROW_STEP      = ADDR_W'(COLS);

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] row_base;
  logic [2:0]        line_in_cell;
  logic [7:0]        col;
  logic [3:0]        next_bits;
  logic [3:0]        cur_bits;

  logic       active_line;
  logic       in_window;
  logic       in_disp;
  logic [1:0] ph;
  logic       slot_free;
  logic       grant;
  logic       fetching;

  assign active_line = (vc >= VC_LO) && (vc < VC_END);
  assign in_window   = active_line && (hc >= HC_FETCH_LO) && (hc <= HC_FETCH_HI);
  assign in_disp     = active_line && (hc >= HC_DISP_LO) && (hc <= HC_DISP_HI);
  assign ph          = hc[1:0] - HC_DISP_LO[1:0];
  // ph0/ph1 of the window are reserved for the display read even when no fetch is running
  assign slot_free   = !(in_window && !ph[1]);
  assign grant       = clr_n && host_req && slot_free;
  assign fetching    = (state == FETCH);
  assign pix_on      = in_disp && cur_bits[ph];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= BLANK;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    host_ack  = grant;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;

    case (state)
      BLANK: if (active_line && hc == HC_FETCH_PRE) state_nx = FETCH;
      FETCH: if (hc == HC_FETCH_HI || !in_window) state_nx = BLANK;
      default: state_nx = BLANK;
    endcase

    if (grant) begin
      ram_addr  = host_addr;
      ram_wdata = host_data;
      ram_we    = (host_addr < CELLS);
    end else if (fetching && ph == 2'd0) begin
      ram_addr = row_base + ADDR_W'(col);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      row_base     <= '0;
      line_in_cell <= '0;
      col          <= '0;
      font_code    <= '0;
      next_bits    <= '0;
      cur_bits     <= '0;
    end else begin
      if (hc == 10'd0) begin
        if (vc == VC_LO) begin
          line_in_cell <= '0;
          row_base     <= '0;
        end else if (active_line) begin
          line_in_cell <= line_in_cell + 3'd1;
          if (line_in_cell == 3'd7) row_base <= row_base + ROW_STEP;
        end
      end

      if (fetching) begin
        case (ph)
          2'd1: font_code <= ram_rdata;
          2'd2: next_bits <= font_gfx[{line_in_cell, 2'b00} +: 4];
          2'd3: begin
            cur_bits <= next_bits;
            col      <= col + 8'd1;
          end
          default: ;
        endcase
      end else begin
        col <= '0;
      end

      // Cleared after the last pixel rather than at window exit, which would drop the final cell
      if (hc == HC_DISP_HI) cur_bits <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_text_fetch_sched.sv
// tb_text_fetch_sched: arbitration vector table, directed corner sequences and
// randomized host traffic checked against a per-pixel reference model.
`default_nettype none

module tb_text_fetch_sched;

  localparam int HBP = 144, VBP = 31, VFP = 511, COLS = 160, ROWS = 60, AW = 14;
  localparam int NCELL = COLS * ROWS;

  logic          clk = 1'b0;
  logic          clr_n;
  logic [9:0]    hc, vc;
  logic          host_req;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_data;
  logic          host_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;
  logic [7:0]    font_code;
  logic [31:0]   font_gfx;
  logic          pix_on;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  text_fetch_sched dut (
    .clk(clk), .clr_n(clr_n), .hc(hc), .vc(vc),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .font_code(font_code), .font_gfx(font_gfx), .pix_on(pix_on)
  );

  function automatic logic [31:0] gfx(input logic [7:0] c);
    if (c == 8'h41) return 32'h12345678;
    return {c ^ 8'hA5, c, ~c, c + 8'h3C};
  endfunction

  function automatic logic [7:0] init_val(input int i);
    if (i == 0) return 8'h41;
    return 8'(i * 37 + 11);
  endfunction

  assign font_gfx = gfx(font_code);

  // Environment text RAM: synchronous read, data valid the cycle after the address
  logic [7:0] ram [0:16383];
  logic       do_init = 1'b0;
  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 16384; i++) ram[i] <= init_val(i);
    end else if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
    ram_rdata <= ram[ram_addr];
  end

  logic [7:0] exp_mem    [0:NCELL-1];
  logic [7:0] line_codes [0:COLS-1];
  bit         line_ok;
  bit         prev_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (vc=%0d hc=%0d)", name, act, exp, vc, hc);
    end
  endtask

  // Reference: derives everything from (vc, hc), the cell memory and the slot rules
  task automatic model_check();
    bit            act_l, win, disp, free, g;
    int            rel, ph, k, row, lin;
    logic [AW-1:0] e_addr;
    logic          e_we, e_pix;
    logic [7:0]    e_wd;
    logic [31:0]   glyph;
    act_l  = (vc >= VBP) && (vc < VFP);
    rel    = int'(hc) - HBP;
    ph     = ((rel % 4) + 4) % 4;
    win    = act_l && (int'(hc) >= HBP - 4) && (int'(hc) <= HBP + 4*COLS - 5);
    disp   = act_l && (rel >= 0) && (rel < 4*COLS);
    free   = !(win && ph < 2);
    g      = clr_n && host_req && free;
    row    = (int'(vc) - VBP) / 8;
    lin    = (int'(vc) - VBP) % 8;
    e_addr = '0; e_we = 1'b0; e_wd = '0; e_pix = 1'b0;
    if (g) begin
      e_addr = host_addr;
      e_we   = (int'(host_addr) < NCELL);
      e_wd   = host_data;
    end else if (clr_n && line_ok && win && ph == 0) begin
      k = (rel + 4) / 4;
      e_addr = AW'(row * COLS + k);
      line_codes[k] = exp_mem[row * COLS + k];
    end
    if (clr_n && line_ok && disp) begin
      k = rel / 4;
      glyph = gfx(line_codes[k]);
      e_pix = glyph[lin * 4 + ph];
    end
    check("host_ack", host_ack, g);
    check("ram_we", ram_we, e_we);
    check("ram_addr", ram_addr, e_addr);
    check("ram_wdata", ram_wdata, e_wd);
    check("pix_on", pix_on, e_pix);
    if (e_we) exp_mem[host_addr] = host_data;
  endtask

  task automatic new_req();
    int a;
    a = $urandom_range(1, 9700);
    if (a == 5) a = 6;
    host_req  = 1'b1;
    host_addr = AW'(a);
    host_data = 8'($urandom);
  endtask

  // mode 0: random host traffic; mode 1: single directed request at ph0 of cell 10
  task automatic run_line(input int v, input int mode, input int rst_at);
    logic [3:0] l0_bits, l1_bits, c5_bits;
    l0_bits = 4'b1000;
    l1_bits = 4'b0111;
    c5_bits = 4'b1110;
    line_ok = (v >= VBP) && (v < VFP);
    for (int h = 0; h < 800; h++) begin
      @(negedge clk);
      vc = 10'(v);
      hc = 10'(h);
      if (rst_at >= 0 && h >= rst_at && h < rst_at + 3) begin
        clr_n     = 1'b0;
        line_ok   = 1'b0;
        host_req  = 1'b1;
        host_addr = 14'd300;
        host_data = 8'h77;
      end else begin
        clr_n = 1'b1;
        if (mode == 1) begin
          if (h == 180) begin
            host_req  = 1'b1;
            host_addr = 14'd777;
            host_data = 8'h99;
          end else if (prev_ack) begin
            host_req = 1'b0;
          end
        end else if (host_req && prev_ack) begin
          if ($urandom_range(0, 1) == 1) new_req(); else host_req = 1'b0;
        end else if (!host_req && $urandom_range(0, 3) == 0) begin
          new_req();
        end
      end
      #1;
      model_check();
      if (v == VBP && h >= 144 && h <= 147) check("t1_line0_cell0", pix_on, l0_bits[h-144]);
      if (v == VBP + 1 && h >= 144 && h <= 147) check("t1_line1_cell0", pix_on, l1_bits[h-144]);
      if (v == VBP && h == 140) check("t2_addr_row0", ram_addr, 0);
      if (v == VBP + 8 && h == 140) check("t2_addr_row1", ram_addr, 160);
      if (v == VFP - 1 && h == 776) check("t2_addr_last", ram_addr, 9599);
      if (mode == 1 && (h == 180 || h == 181)) check("t3_no_ack_ph0_ph1", host_ack, 0);
      if (mode == 1 && h == 182) begin
        check("t3_ack_ph2", host_ack, 1);
        check("t3_we_ph2", ram_we, 1);
        check("t3_addr_ph2", ram_addr, 777);
      end
      if (rst_at >= 0 && h >= 164 && h <= 167) check("t4_cell5_glyph", pix_on, c5_bits[h-164]);
      if (rst_at >= 0 && h == rst_at) begin
        check("t6_rst_pix", pix_on, 0);
        check("t6_rst_ack", host_ack, 0);
        check("t6_rst_we", ram_we, 0);
      end
      prev_ack = host_ack;
    end
  endtask

  task automatic fast_lines(input int v_from, input int v_to);
    for (int v = v_from; v <= v_to; v++) begin
      @(negedge clk);
      vc       = 10'(v);
      hc       = 10'd0;
      host_req = 1'b0;
    end
    prev_ack = 1'b0;
  endtask

  typedef struct {
    logic [9:0]    hc;
    logic [9:0]    vc;
    logic          req;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          ack;
    logic          we;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int diffs;
    vecs.push_back('{10'd790, 10'd100, 1'b1, 14'd5,    8'h42, 1'b1, 1'b1});
    vecs.push_back('{10'd700, 10'd100, 1'b1, 14'd77,   8'h11, 1'b0, 1'b0});
    vecs.push_back('{10'd701, 10'd100, 1'b1, 14'd77,   8'h11, 1'b0, 1'b0});
    vecs.push_back('{10'd702, 10'd100, 1'b1, 14'd77,   8'h11, 1'b1, 1'b1});
    vecs.push_back('{10'd703, 10'd100, 1'b1, 14'd78,   8'h12, 1'b1, 1'b1});
    vecs.push_back('{10'd140, 10'd100, 1'b1, 14'd79,   8'h13, 1'b0, 1'b0});
    vecs.push_back('{10'd779, 10'd100, 1'b1, 14'd80,   8'h14, 1'b1, 1'b1});
    vecs.push_back('{10'd780, 10'd100, 1'b1, 14'd81,   8'h15, 1'b1, 1'b1});
    vecs.push_back('{10'd700, 10'd10,  1'b1, 14'd82,   8'h16, 1'b1, 1'b1});
    vecs.push_back('{10'd700, 10'd511, 1'b1, 14'd83,   8'h17, 1'b1, 1'b1});
    vecs.push_back('{10'd700, 10'd510, 1'b1, 14'd84,   8'h18, 1'b0, 1'b0});
    vecs.push_back('{10'd141, 10'd31,  1'b1, 14'd85,   8'h19, 1'b0, 1'b0});
    vecs.push_back('{10'd790, 10'd100, 1'b1, 14'd9600, 8'h20, 1'b1, 1'b0});
    vecs.push_back('{10'd790, 10'd100, 1'b1, 14'd9599, 8'h21, 1'b1, 1'b1});
    vecs.push_back('{10'd790, 10'd100, 1'b0, 14'd86,   8'h22, 1'b0, 1'b0});
    vecs.push_back('{10'd700, 10'd30,  1'b1, 14'd87,   8'h23, 1'b1, 1'b1});

    clr_n = 1'b0; hc = '0; vc = '0;
    host_req = 1'b1; host_addr = 14'd5; host_data = 8'h42;
    prev_ack = 1'b0; line_ok = 1'b0;
    do_init = 1'b1;
    @(negedge clk);
    do_init = 1'b0;
    for (int i = 0; i < NCELL; i++) exp_mem[i] = init_val(i);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst_ack", host_ack, 0);
      check("rst_we", ram_we, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_wdata", ram_wdata, 0);
      check("rst_pix", pix_on, 0);
      check("rst_font_code", font_code, 0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      clr_n     = 1'b1;
      hc        = vecs[i].hc;
      vc        = vecs[i].vc;
      host_req  = vecs[i].req;
      host_addr = vecs[i].addr;
      host_data = vecs[i].data;
      #1;
      check($sformatf("vec%0d_ack", i), host_ack, vecs[i].ack);
      check($sformatf("vec%0d_we", i), ram_we, vecs[i].we);
      check($sformatf("vec%0d_addr", i), ram_addr, vecs[i].ack ? vecs[i].addr : 14'd0);
      check($sformatf("vec%0d_wdata", i), ram_wdata, vecs[i].ack ? vecs[i].data : 8'd0);
      if (vecs[i].we) exp_mem[vecs[i].addr] = vecs[i].data;
    end
    fast_lines(0, 30);

    run_line(31, 0, -1);
    run_line(32, 0, -1);
    run_line(33, 0, -1);
    run_line(34, 0, -1);
    fast_lines(35, 38);
    run_line(39, 0, -1);
    fast_lines(40, 99);
    run_line(100, 1, -1);
    fast_lines(101, 509);
    run_line(510, 0, -1);
    fast_lines(511, 520);
    run_line(31, 0, 300);
    run_line(32, 0, -1);
    run_line(33, 0, -1);
    fast_lines(34, 34);

    @(negedge clk);
    diffs = 0;
    for (int i = 0; i < NCELL; i++) if (ram[i] !== exp_mem[i]) diffs++;
    check("ram_contents", diffs, 0);
    check("t5_oob_untouched", ram[9600], init_val(9600));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
